mult_execute_unit: RTL and testbench
====================================

MULT_EXECUTE_UNIT -- requirements
Module: mult_execute_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand and result width.
REQ-002 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin a multiply; honoured only when busy=0.
REQ-005 SHALL have port mult_op, input, 2, operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-006 SHALL have ports operand_A and operand_B, input, DATA_WIDTH, rs1/rs2 values.
REQ-007 SHALL have ports rd_in (input, 5) and regWrite_in (input, 1), destination tag and write enable carried with the operation.
REQ-008 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-009 SHALL have port MULT_ready, output, 1, one-cycle result-valid pulse to the downstream MULT pipe.
REQ-010 SHALL have ports ALU_result_execute (output, DATA_WIDTH), rd_execute (output, 5) and regWrite_execute (output, 1), result, tag and enable.

Function
REQ-011 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-012 In IDLE with start=1, SHALL latch operands, mult_op, rd_in and regWrite_in, and enter RUN at the same edge; start in RUN or DONE SHALL be ignored with no queuing.
REQ-013 At accept, SHALL convert signed operands to magnitudes: A signed for MULH/MULHSU; B signed for MULH only; MUL and MULHU treat both as unsigned; result sign = XOR of the sign bits of the operands treated as signed.
REQ-014 RUN SHALL perform one shift-add step per cycle on a 2*DATA_WIDTH-bit product register, for exactly DATA_WIDTH cycles, counted by a counter of width log2(DATA_WIDTH)+1.
REQ-015 On the edge leaving RUN, SHALL two's-complement-negate the 2*DATA_WIDTH product when the result sign=1 and load ALU_result_execute with the low half for MUL and the high half otherwise.
REQ-016 In DONE, MULT_ready SHALL be 1 for exactly one cycle, with rd_execute and regWrite_execute from the latched values; the next edge returns to IDLE.
REQ-017 For start accepted at edge E, MULT_ready SHALL be high in the cycle after edge E+DATA_WIDTH, giving a latency of DATA_WIDTH+1 cycles.
REQ-018 ALU_result_execute, rd_execute and regWrite_execute SHALL hold their values until the next DONE.
REQ-019 Consecutive MULT_ready pulses SHALL be at least 2 cycles apart, which the downstream stage requires.
REQ-020 Overflow SHALL wrap silently; there are no exceptions.

Reset
REQ-021 Reset SHALL force IDLE at once, asynchronously, discarding any in-flight operation.
REQ-022 Under reset, all outputs SHALL be 0: busy, MULT_ready, ALU_result_execute, rd_execute and regWrite_execute.
REQ-023 After reset deasserts, start SHALL be accepted on the first edge.

Configuration
REQ-024 Macro MULT_ZERO_BYPASS_EN, when defined: start with operand_A=0 or operand_B=0 SHALL go IDLE -> DONE directly, with result 0 and latency 1 cycle (MULT_ready high in the cycle after the accept edge).
REQ-025 When MULT_ZERO_BYPASS_EN is undefined, zero operands SHALL take the full DATA_WIDTH+1-cycle path and produce result 0.

Verification
REQ-026 MUL 7*6, rd_in=5, regWrite_in=1 -> MULT_ready pulse 33 cycles after accept; ALU_result_execute=42, rd_execute=5, regWrite_execute=1.
REQ-027 MULH 0x80000000*0x80000000 -> 0x40000000; MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001.
REQ-028 MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-029 MUL 3*4 accepted, with a second start (MUL 9*9) pulsed 10 cycles later -> only one MULT_ready pulse, result 12; no second pulse.
REQ-030 Reset asserted 15 cycles into RUN -> busy=0 and all outputs 0 immediately; no MULT_ready; next start 2*2 -> 4.
REQ-031 MUL 0*0x1234 -> result 0; MULT_ready 1 cycle after accept with MULT_ZERO_BYPASS_EN, 33 cycles after accept without it.

Source files
------------

// File: rtl/mult_execute_unit.sv
// Iterative shift-add multiplier for the RISC-V M-extension multiply ops (MUL/MULH/MULHSU/MULHU).
// Optional macro MULT_ZERO_BYPASS_EN: a zero operand skips RUN and completes in one cycle.
module mult_execute_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mult_op,
  input  logic [DATA_WIDTH-1:0] operand_A,
  input  logic [DATA_WIDTH-1:0] operand_B,
  input  logic [4:0]            rd_in,
  input  logic                  regWrite_in,
  output logic                  busy,
  output logic                  MULT_ready,
  output logic [DATA_WIDTH-1:0] ALU_result_execute,
  output logic [4:0]            rd_execute,
  output logic                  regWrite_execute
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2*W-1:0]  prod_q;
  logic [W-1:0]    mcand_q;
  logic            neg_q;
  logic            hi_q;
  logic [4:0]      rd_lat_q;
  logic            rw_lat_q;
  logic [W-1:0]    result_q;
  logic [4:0]      rd_q;
  logic            rw_q;
  logic            ready_q;
  logic            busy_q;

  logic            a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      sum_d;
  logic [2*W-1:0]  prod_d;
  logic [2*W-1:0]  final_d;
  logic            last_step;
  logic            zero_op;

  // MULH and MULHSU read rs1 as signed; only MULH reads rs2 as signed.
  assign a_neg = ((mult_op == 2'b01) || (mult_op == 2'b10)) && operand_A[W-1];
  assign b_neg = (mult_op == 2'b01) && operand_B[W-1];
  assign a_mag = a_neg ? -operand_A : operand_A;
  assign b_mag = b_neg ? -operand_B : operand_B;

`ifdef MULT_ZERO_BYPASS_EN
  assign zero_op = (operand_A == '0) || (operand_B == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Multiplier sits in the low half and shifts out LSB-first while partial sums enter the top.
  assign sum_d     = prod_q[0] ? ({1'b0, prod_q[2*W-1:W]} + {1'b0, mcand_q})
                               : {1'b0, prod_q[2*W-1:W]};
  assign prod_d    = {sum_d, prod_q[W-1:1]};
  assign final_d   = neg_q ? -prod_d : prod_d;
  assign last_step = (cnt_q == CW'(DATA_WIDTH - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      hi_q     <= 1'b0;
      rd_lat_q <= '0;
      rw_lat_q <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      rw_q     <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            busy_q   <= 1'b1;
            rd_lat_q <= rd_in;
            rw_lat_q <= regWrite_in;
            if (zero_op) begin
              state_q  <= DONE;
              ready_q  <= 1'b1;
              result_q <= '0;
              rd_q     <= rd_in;
              rw_q     <= regWrite_in;
            end else begin
              state_q <= RUN;
              mcand_q <= a_mag;
              prod_q  <= {{W{1'b0}}, b_mag};
              neg_q   <= a_neg ^ b_neg;
              hi_q    <= (mult_op != 2'b00);
              cnt_q   <= '0;
            end
          end
        end
        RUN: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q + CW'(1);
          if (last_step) begin
            state_q  <= DONE;
            ready_q  <= 1'b1;
            result_q <= hi_q ? final_d[2*W-1:W] : final_d[W-1:0];
            rd_q     <= rd_lat_q;
            rw_q     <= rw_lat_q;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy               = busy_q;
  assign MULT_ready         = ready_q;
  assign ALU_result_execute = result_q;
  assign rd_execute         = rd_q;
  assign regWrite_execute   = rw_q;

endmodule

// File: tb/tb_mult_execute_unit.sv
// Scoreboard bench for mult_execute_unit: directed cases plus randomized ops against a 2W-bit arithmetic model.
module tb_mult_execute_unit;

  localparam int W = 32;
`ifdef MULT_ZERO_BYPASS_EN
  localparam int ZLAT = 0;
`else
  localparam int ZLAT = W;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mult_op = 2'b00;
  logic [W-1:0]  operand_A = '0;
  logic [W-1:0]  operand_B = '0;
  logic [4:0]    rd_in = '0;
  logic          regWrite_in = 1'b0;
  logic          busy;
  logic          MULT_ready;
  logic [W-1:0]  ALU_result_execute;
  logic [4:0]    rd_execute;
  logic          regWrite_execute;

  mult_execute_unit #(.DATA_WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .mult_op(mult_op),
    .operand_A(operand_A), .operand_B(operand_B), .rd_in(rd_in), .regWrite_in(regWrite_in),
    .busy(busy), .MULT_ready(MULT_ready), .ALU_result_execute(ALU_result_execute),
    .rd_execute(rd_execute), .regWrite_execute(regWrite_execute)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic [4:0]   rd;
    logic         rw;
    int           due;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: widen operands by their signedness and take the needed half of the 2W-bit product.
  function automatic logic [W-1:0] ref_mul(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] ax, bx, p;
    ax = (op == 2'b01 || op == 2'b10) ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    bx = (op == 2'b01) ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    p  = ax * bx;
    return (op == 2'b00) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  // Monitor: every MULT_ready pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && MULT_ready) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_pulse: got MULT_ready=1 at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("result cycle %0d: res=%h rd=%0d rw=%0d (expect %h/%0d/%0d due %0d)",
                 cyc, ALU_result_execute, rd_execute, regWrite_execute, e.res, e.rd, e.rw, e.due);
        chk("result", 64'(ALU_result_execute), 64'(e.res));
        chk("rd", 64'(rd_execute), 64'(e.rd));
        chk("regwrite", 64'(regWrite_execute), 64'(e.rw));
        chk("latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] rd, input logic rw, input bit accepted);
    exp_t e;
    @(negedge clock);
    mult_op = op; operand_A = a; operand_B = b; rd_in = rd; regWrite_in = rw; start = 1'b1;
    if (accepted) begin
      e.res = ref_mul(op, a, b);
      e.rd  = rd;
      e.rw  = rw;
      e.due = cyc + 1 + (((a == '0) || (b == '0)) ? ZLAT : W);
      sb.push_back(e);
    end
    $display("issue cycle %0d: op=%0d a=%h b=%h rd=%0d rw=%0d accepted=%0d", cyc, op, a, b, rd, rw, accepted);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 200) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n >= 200) begin
      fails++;
      $display("FAIL idle_timeout: got busy=%0d pending=%0d, expected idle within 200 cycles", busy, sb.size());
      sb.delete();
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return {W{1'b1}};
      2: return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(MULT_ready), 64'd0);
    chk("rst_result", 64'(ALU_result_execute), 64'd0);
    chk("rst_rd", 64'(rd_execute), 64'd0);
    chk("rst_rw", 64'(regWrite_execute), 64'd0);
    reset = 1'b0;

    issue(2'b00, 32'd7, 32'd6, 5'd5, 1'b1, 1'b1);
    wait_idle();
    repeat (3) @(negedge clock);
    chk("hold_result", 64'(ALU_result_execute), 64'd42);
    chk("hold_rd", 64'(rd_execute), 64'd5);
    chk("hold_rw", 64'(regWrite_execute), 64'd1);

    issue(2'b01, 32'h80000000, 32'h80000000, 5'd1, 1'b1, 1'b1); wait_idle();
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 1'b1, 1'b1); wait_idle();
    issue(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 1'b0, 1'b1); wait_idle();
    issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 1'b1, 1'b1); wait_idle();

    // Start while RUN must be dropped, not queued.
    issue(2'b00, 32'd3, 32'd4, 5'd6, 1'b1, 1'b1);
    repeat (8) @(negedge clock);
    issue(2'b00, 32'd9, 32'd9, 5'd7, 1'b1, 1'b0);
    wait_idle();
    repeat (W + 5) @(negedge clock);

    // Reset in the middle of RUN.
    issue(2'b00, 32'h1234, 32'h5678, 5'd8, 1'b1, 1'b1);
    repeat (14) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ready", 64'(MULT_ready), 64'd0);
    chk("midrst_result", 64'(ALU_result_execute), 64'd0);
    chk("midrst_rd", 64'(rd_execute), 64'd0);
    chk("midrst_rw", 64'(regWrite_execute), 64'd0);
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    issue(2'b00, 32'd2, 32'd2, 5'd9, 1'b1, 1'b1); wait_idle();

    issue(2'b00, 32'd0, 32'h1234, 5'd10, 1'b1, 1'b1); wait_idle();

    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick(), 5'($urandom), 1'($urandom), 1'b1);
      wait_idle();
    end

    repeat (4) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
